// File: rtl/clock_switch_sequencer_if.sv
// Handshake bundle between the external-clock detector / DCM and the
// clock switch sequencer.
//   clk1_present : detector verdict, 1 = external clock present
//   switching    : detector changeover flag, 3-cycle level pulse per change
//   dcm_locked   : DCM lock indication, asynchronous to the sequencer clock
//   clk_select   : global clock mux select, 0 = internal, 1 = external
//   dcm_reset    : DCM reset
//   sys_reset    : downstream synchronous reset
//   ready        : clocking is stable
//   lock_fail    : last attempt on the external clock timed out
//   switch_count : number of clk_select transitions (wraps)
interface clock_switch_sequencer_if;
    localparam int unsigned COUNT_W = 8;

    logic               clk1_present;
    logic               switching;
    logic               dcm_locked;
    logic               clk_select;
    logic               dcm_reset;
    logic               sys_reset;
    logic               ready;
    logic               lock_fail;
    logic [COUNT_W-1:0] switch_count;

    // Detector / DCM side (drives requests, observes the sequencer).
    modport master (
        output clk1_present,
        output switching,
        output dcm_locked,
        input  clk_select,
        input  dcm_reset,
        input  sys_reset,
        input  ready,
        input  lock_fail,
        input  switch_count
    );

    // Sequencer side.
    modport slave (
        input  clk1_present,
        input  switching,
        input  dcm_locked,
        output clk_select,
        output dcm_reset,
        output sys_reset,
        output ready,
        output lock_fail,
        output switch_count
    );
endinterface

// File: rtl/clock_switch_sequencer.sv
// Clock changeover sequencer, running on the always-on internal clock.
// On each detector announcement it holds the system in reset, steers the
// global clock mux, pulses the DCM reset, waits for a stable lock and then
// releases the system. An external clock that never locks falls back to the
// internal clock; failure to lock on the internal clock parks in FAULT.
//   clk   : internal clock, always running
//   reset : asynchronous active-high reset
//   bus   : detector / DCM handshake (slave modport), all outputs registered
module clock_switch_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned LOCK_TIMEOUT  = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    clock_switch_sequencer_if.slave        bus
);
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned COUNT_W = 8;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_QUIESCE   = 3'd1;
    localparam logic [2:0] S_SELECT    = 3'd2;
    localparam logic [2:0] S_WAIT_LOCK = 3'd3;
    localparam logic [2:0] S_RELEASE   = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    logic [2:0]         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               target, target_nxt;
    logic               req, req_nxt;
    logic               pending, pending_nxt;

    logic               lock_meta, lock_s;
    logic               sw_q, sw_q_d, c1_q;
    logic               trig;
    logic               req_eff;

    logic               clk_select_r, clk_select_nxt;
    logic               dcm_reset_r, dcm_reset_nxt;
    logic               sys_reset_r, sys_reset_nxt;
    logic               ready_r, ready_nxt;
    logic               lock_fail_r, lock_fail_nxt;
    logic [COUNT_W-1:0] switch_count_r, switch_count_nxt;

    // Lock synchronizer; flushed while the DCM is held in reset so a stale
    // lock from before the DCM reset cannot release the system early.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else if (dcm_reset_r) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.dcm_locked;
            lock_s    <= lock_meta;
        end
    end

    // Detector inputs registered; clk1_present travels with switching so the
    // verdict latched on the trigger is aligned with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_q   <= 1'b0;
            sw_q_d <= 1'b0;
            c1_q   <= 1'b0;
        end else begin
            sw_q   <= bus.switching;
            sw_q_d <= sw_q;
            c1_q   <= bus.clk1_present;
        end
    end

    // Falling edge of the registered changeover flag.
    assign trig    = sw_q_d & ~sw_q;
    // Request as seen this cycle: a fresh trigger supersedes the latched one.
    assign req_eff = trig ? c1_q : req;

    // State register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_SELECT;
            cnt            <= '0;
            target         <= 1'b0;
            req            <= 1'b0;
            pending        <= 1'b0;
            clk_select_r   <= 1'b0;
            dcm_reset_r    <= 1'b1;
            sys_reset_r    <= 1'b1;
            ready_r        <= 1'b0;
            lock_fail_r    <= 1'b0;
            switch_count_r <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            target         <= target_nxt;
            req            <= req_nxt;
            pending        <= pending_nxt;
            clk_select_r   <= clk_select_nxt;
            dcm_reset_r    <= dcm_reset_nxt;
            sys_reset_r    <= sys_reset_nxt;
            ready_r        <= ready_nxt;
            lock_fail_r    <= lock_fail_nxt;
            switch_count_r <= switch_count_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        target_nxt     = target;
        lock_fail_nxt  = lock_fail_r;
        clk_select_nxt = clk_select_r;
        req_nxt        = req_eff;
        // Triggers while busy collapse into one flag; req keeps the latest.
        pending_nxt    = pending | (trig & (state != S_IDLE));

        case (state)
            S_IDLE: begin
                pending_nxt = 1'b0;
                // A trigger beats a simultaneous lock loss.
                if ((trig || pending) && (req_eff != clk_select_r)) begin
                    target_nxt    = req_eff;
                    lock_fail_nxt = 1'b0;
                    state_nxt     = S_QUIESCE;
                    cnt_nxt       = '0;
                end else if (!lock_s) begin
                    state_nxt = S_QUIESCE;
                    cnt_nxt   = '0;
                end
            end

            S_QUIESCE: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt      = S_SELECT;
                    cnt_nxt        = '0;
                    clk_select_nxt = target;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_SELECT: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = S_RELEASE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt = '0;
                    if (target) begin
                        // External clock never locked: retry on internal.
                        target_nxt     = 1'b0;
                        lock_fail_nxt  = 1'b1;
                        clk_select_nxt = 1'b0;
                        state_nxt      = S_SELECT;
                    end else begin
                        state_nxt = S_FAULT;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_RELEASE: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_FAULT: begin
                clk_select_nxt = 1'b0;
            end

            default: begin
                // Unreachable encoding: restart a lock on the internal clock.
                state_nxt      = S_SELECT;
                cnt_nxt        = '0;
                target_nxt     = 1'b0;
                clk_select_nxt = 1'b0;
            end
        endcase

        dcm_reset_nxt    = (state_nxt == S_SELECT) || (state_nxt == S_FAULT);
        sys_reset_nxt    = (state_nxt != S_IDLE);
        ready_nxt        = (state_nxt == S_IDLE);
        switch_count_nxt = switch_count_r + COUNT_W'(clk_select_nxt ^ clk_select_r);
    end

    assign bus.clk_select   = clk_select_r;
    assign bus.dcm_reset    = dcm_reset_r;
    assign bus.sys_reset    = sys_reset_r;
    assign bus.ready        = ready_r;
    assign bus.lock_fail    = lock_fail_r;
    assign bus.switch_count = switch_count_r;
endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Directed bench for clock_switch_sequencer: expected latencies and output
// snapshots are queued when stimulus is applied and popped when the DUT
// reaches the corresponding point.
module tb_clock_switch_sequencer;
    localparam int SEL_SYS_RESET = 0;
    localparam int SEL_READY     = 1;
    localparam int SEL_DCM_RESET = 2;
    localparam int SEL_CLK_SEL   = 3;
    localparam int SEL_LOCK_FAIL = 4;

    typedef struct {
        string tag;
        int    val;
    } lat_t;

    typedef struct {
        string      tag;
        logic       cs;
        logic       dr;
        logic       sr;
        logic       rdy;
        logic       lf;
        logic [7:0] cnt;
    } snap_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    lat_t  lat_q[$];
    snap_t snap_q[$];

    clock_switch_sequencer_if bus();

    clock_switch_sequencer #(
        .HOLD_CYCLES   (16),
        .SETTLE_CYCLES (8),
        .LOCK_TIMEOUT  (4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_SYS_RESET: return bus.sys_reset;
            SEL_READY:     return bus.ready;
            SEL_DCM_RESET: return bus.dcm_reset;
            SEL_CLK_SEL:   return bus.clk_select;
            default:       return bus.lock_fail;
        endcase
    endfunction

    // Ticks until the selected output equals val; the bound is itself checked.
    task automatic wait_sig(input int sel, input logic val, input int budget,
                            input string tag, output int n);
        n = 0;
        while (sig(sel) !== val && n < budget) begin
            tick();
            n++;
        end
        cmp({tag, "_reached"}, 32'(sig(sel) === val), 32'd1);
    endtask

    task automatic exp_lat(input string tag, input int val);
        lat_t e;
        e.tag = tag;
        e.val = val;
        lat_q.push_back(e);
    endtask

    task automatic chk_lat(input int n);
        lat_t e;
        e = lat_q.pop_front();
        cmp(e.tag, 32'(n), 32'(e.val));
    endtask

    task automatic exp_snap(input string tag, input logic cs, input logic dr, input logic sr,
                            input logic rdy, input logic lf, input logic [7:0] cnt);
        snap_t e;
        e.tag = tag; e.cs = cs; e.dr = dr; e.sr = sr; e.rdy = rdy; e.lf = lf; e.cnt = cnt;
        snap_q.push_back(e);
    endtask

    task automatic chk_snap();
        snap_t e;
        e = snap_q.pop_front();
        cmp({e.tag, ".clk_select"},   32'(bus.clk_select),   32'(e.cs));
        cmp({e.tag, ".dcm_reset"},    32'(bus.dcm_reset),    32'(e.dr));
        cmp({e.tag, ".sys_reset"},    32'(bus.sys_reset),    32'(e.sr));
        cmp({e.tag, ".ready"},        32'(bus.ready),        32'(e.rdy));
        cmp({e.tag, ".lock_fail"},    32'(bus.lock_fail),    32'(e.lf));
        cmp({e.tag, ".switch_count"}, 32'(bus.switch_count), 32'(e.cnt));
    endtask

    // Three-cycle switching pulse; the falling edge is driven on return.
    task automatic pulse(input logic present);
        bus.clk1_present = present;
        bus.switching    = 1'b1;
        repeat (3) tick();
        bus.switching    = 1'b0;
    endtask

    task automatic do_reset_and_lock(input string tag);
        int n;
        reset            = 1'b1;
        bus.dcm_locked   = 1'b1;
        bus.clk1_present = 1'b0;
        bus.switching    = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        wait_sig(SEL_READY, 1'b1, 100, tag, n);
    endtask

    initial begin
        int n;
        int bad;

        // Power-up: reset values, then lock on the internal clock.
        reset            = 1'b1;
        bus.clk1_present = 1'b0;
        bus.switching    = 1'b0;
        bus.dcm_locked   = 1'b1;
        exp_snap("reset_vals", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        repeat (3) tick();
        chk_snap();
        exp_lat("pwr_dcm_reset_len", 8);
        exp_lat("pwr_release_after_select", 2 + 1 + 8);
        exp_snap("pwr_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        reset = 1'b0;
        wait_sig(SEL_DCM_RESET, 1'b0, 50, "pwr_dcm", n);
        chk_lat(n);
        wait_sig(SEL_READY, 1'b1, 50, "pwr_ready", n);
        chk_lat(n);
        chk_snap();

        // External switch with lock held.
        exp_lat("ext_trigger_latency", 2);
        exp_lat("ext_hold_to_select", 16);
        exp_snap("ext_select", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        exp_snap("ext_idle", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        pulse(1'b1);
        wait_sig(SEL_SYS_RESET, 1'b1, 10, "ext_sysrst", n);
        chk_lat(n);
        wait_sig(SEL_CLK_SEL, 1'b1, 40, "ext_cs", n);
        chk_lat(n);
        chk_snap();
        wait_sig(SEL_READY, 1'b1, 100, "ext_ready", n);
        chk_snap();

        // One-cycle lock loss in IDLE: re-lock with select and count untouched.
        exp_lat("relock_detect", 2);
        exp_snap("relock_idle", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        bus.dcm_locked = 1'b0;
        tick();
        bus.dcm_locked = 1'b1;
        wait_sig(SEL_SYS_RESET, 1'b1, 10, "relock_sysrst", n);
        chk_lat(n);
        wait_sig(SEL_READY, 1'b1, 100, "relock_ready", n);
        chk_snap();

        // Switch back to internal, then reset asynchronously in WAIT_LOCK.
        exp_lat("back_select_len", 8);
        exp_snap("midreset_vals", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        pulse(1'b0);
        wait_sig(SEL_CLK_SEL, 1'b0, 40, "back_cs", n);
        cmp("back_count", 32'(bus.switch_count), 32'd2);
        bus.dcm_locked = 1'b0;
        wait_sig(SEL_DCM_RESET, 1'b0, 20, "back_wait_lock", n);
        chk_lat(n);
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        chk_snap();

        // Lock timeout on the external clock falls back to internal.
        do_reset_and_lock("to_pwr");
        exp_lat("to_timeout", 8 + 4096);
        exp_snap("to_fallback", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
        exp_snap("to_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
        pulse(1'b1);
        wait_sig(SEL_CLK_SEL, 1'b1, 40, "to_cs", n);
        bus.dcm_locked = 1'b0;
        wait_sig(SEL_LOCK_FAIL, 1'b1, 5000, "to_lf", n);
        chk_lat(n);
        chk_snap();
        bus.dcm_locked = 1'b1;
        wait_sig(SEL_READY, 1'b1, 100, "to_ready", n);
        chk_snap();

        // Double fault: no lock on either clock parks in FAULT until reset.
        do_reset_and_lock("df_pwr");
        exp_lat("df_first_timeout", 8 + 4096);
        exp_lat("df_internal_select", 8);
        exp_lat("df_second_timeout", 4096);
        exp_snap("df_fault", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
        pulse(1'b1);
        wait_sig(SEL_CLK_SEL, 1'b1, 40, "df_cs", n);
        bus.dcm_locked = 1'b0;
        wait_sig(SEL_LOCK_FAIL, 1'b1, 5000, "df_lf", n);
        chk_lat(n);
        wait_sig(SEL_DCM_RESET, 1'b0, 20, "df_wait", n);
        chk_lat(n);
        wait_sig(SEL_DCM_RESET, 1'b1, 5000, "df_fault_entry", n);
        chk_lat(n);
        bus.dcm_locked = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.dcm_reset !== 1'b1 || bus.sys_reset !== 1'b1 ||
                bus.ready !== 1'b0 || bus.clk_select !== 1'b0)
                bad++;
        end
        cmp("df_fault_hold", 32'(bad), 32'd0);
        chk_snap();

        // Triggers while busy: last request (0) runs after the first switch.
        do_reset_and_lock("busy_pwr");
        exp_snap("busy_first", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        exp_snap("busy_pending_start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        exp_snap("busy_second", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
        pulse(1'b1);
        tick();
        pulse(1'b1);
        tick();
        pulse(1'b0);
        wait_sig(SEL_READY, 1'b1, 100, "busy_ready1", n);
        chk_snap();
        tick();
        chk_snap();
        wait_sig(SEL_CLK_SEL, 1'b0, 40, "busy_cs0", n);
        wait_sig(SEL_READY, 1'b1, 100, "busy_ready2", n);
        chk_snap();

        cmp("sb_lat_drained", 32'(lat_q.size()), 32'd0);
        cmp("sb_snap_drained", 32'(snap_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
